// File: rtl/fifo_drain_pkg.sv
// Shared types for the FIFO drain controller: FSM state encoding and the
// output-buffer entry layout.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  localparam int default_width = 8;

  typedef struct packed {
    logic [default_width-1:0] data;
    logic                     last;
  } buf_entry_t;

endpackage

// File: rtl/out_buf2.sv
// Two-entry in-order queue carrying a data word plus its last-word marker.
// Breaks the path from downstream ready back to the producer.
module out_buf2 #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             push_last,
  input  logic             ready,
  output logic             valid,
  output logic [width-1:0] data,
  output logic             last,
  output logic [1:0]       count
);

  // Same layout as fifo_drain_pkg::buf_entry_t, sized by this instance's width.
  typedef struct packed {
    logic [width-1:0] data;
    logic             last;
  } entry_t;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       xfer;

  // Handshake: a word moves downstream on every cycle where valid && ready;
  // valid never depends on ready, and data/last hold while valid && !ready.
  // The producer only pushes when count < 2.
  assign xfer  = valid && ready;
  assign valid = (cnt != 2'd0);
  assign data  = mem[rd_ptr].data;
  assign last  = valid && mem[rd_ptr].last;
  assign count = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: push_data, last: push_last};
        wr_ptr      <= ~wr_ptr;
      end
      if (xfer) rd_ptr <= ~rd_ptr;
      case ({push, xfer})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Pop-side controller for the show-ahead FIFO: drains a counted or
// until-empty burst onto a valid/ready stream with a last-word marker.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int width = 8,
  parameter int len_w = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_data,
  output logic             fifo_pop_req_n,
  input  logic             drain_start,
  input  logic [len_w-1:0] drain_len,
  input  logic             abort,
  output logic             m_valid,
  output logic [width-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic [len_w-1:0] word_count,
  output logic [1:0]       dbg_state
);

  drain_state_t     state;
  logic [len_w-1:0] remaining;
  logic             unbounded;
  logic [1:0]       buf_count;
  logic             pop;
  logic             pop_last;

  // Pop only looks at registered buffer occupancy, never at m_ready.
  assign pop = (state == DRAIN) && !fifo_empty && (buf_count < 2'd2) && !abort &&
               (unbounded || (remaining != '0));
  assign pop_last       = pop && !unbounded && (remaining == len_w'(1));
  assign fifo_pop_req_n = !pop;
  assign busy           = (state != IDLE);
  assign dbg_state      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      unbounded  <= 1'b0;
      word_count <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the old burst.
          if (drain_start && !done) begin
            state      <= DRAIN;
            remaining  <= drain_len;
            unbounded  <= (drain_len == '0);
            word_count <= '0;
          end
        end
        DRAIN: begin
          if (pop) begin
            if (word_count != '1) word_count <= word_count + len_w'(1);
            if (!unbounded) remaining <= remaining - len_w'(1);
          end
          if ((!unbounded && (remaining == '0)) || abort || (unbounded && fifo_empty))
            state <= FLUSH;
        end
        FLUSH: begin
          if (buf_count == 2'd0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  out_buf2 #(.width(width)) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pop),
    .push_data (fifo_data),
    .push_last (pop_last),
    .ready     (m_ready),
    .valid     (m_valid),
    .data      (m_data),
    .last      (m_last),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural show-ahead FIFO,
// a transfer monitor and hand-computed expectations.
module tb_fifo_drain_ctrl;

  localparam int width = 8;
  localparam int len_w = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_empty;
  logic [width-1:0] fifo_data;
  logic             fifo_pop_req_n;
  logic             drain_start = 1'b0;
  logic [len_w-1:0] drain_len = '0;
  logic             abort = 1'b0;
  logic             m_valid;
  logic [width-1:0] m_data;
  logic             m_last;
  logic             m_ready = 1'b0;
  logic             busy;
  logic             done;
  logic [len_w-1:0] word_count;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  fifo_drain_ctrl #(.width(width), .len_w(len_w)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_pop_req_n (fifo_pop_req_n),
    .drain_start    (drain_start),
    .drain_len      (drain_len),
    .abort          (abort),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .busy           (busy),
    .done           (done),
    .word_count     (word_count),
    .dbg_state      (dbg_state)
  );

  // behavioural show-ahead FIFO, cleared by the shared reset
  logic [width-1:0] fifo_mem [256];
  logic [7:0]       wr_ptr = 8'd0;
  logic [7:0]       rd_ptr = 8'd0;
  int               pop_cnt = 0;
  int               pop_err = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (!fifo_pop_req_n) begin
      pop_cnt <= pop_cnt + 1;
      if (wr_ptr == rd_ptr) pop_err <= pop_err + 1;
      else rd_ptr <= rd_ptr + 8'd1;
    end
  end

  // scoreboard: observed transfers as {last, data}
  logic [width:0] rx_q[$];
  int             done_cnt = 0;

  always @(negedge clk) begin
    if (m_valid && m_ready) rx_q.push_back({m_last, m_data});
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rx(input string tag, input int base, input int idx,
                          input logic [width-1:0] d, input logic l);
    logic [width:0] got;
    got = (base + idx < rx_q.size()) ? rx_q[base + idx] : '1;
    check(tag, {23'd0, got}, {23'd0, l, d});
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [width-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic start_drain(input logic [len_w-1:0] len);
    drain_len   = len;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!done && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc0, rb, dc, busy_bad;

    // reset state
    repeat (3) tick();
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_pop_req_n", {31'd0, fifo_pop_req_n}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_word_count", {24'd0, word_count}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: bounded drain of 3 out of 5
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'h11 + 8'(i));
    pc0 = pop_cnt; rb = rx_q.size(); dc = done_cnt;
    start_drain(8'd3);
    wait_done("s1", 40);
    tick(); tick();
    check("s1_pops", pop_cnt - pc0, 3);
    check("s1_rx_n", rx_q.size() - rb, 3);
    check_rx("s1_w0", rb, 0, 8'h11, 1'b0);
    check_rx("s1_w1", rb, 1, 8'h12, 1'b0);
    check_rx("s1_w2", rb, 2, 8'h13, 1'b1);
    check("s1_done_n", done_cnt - dc, 1);
    check("s1_word_count", {24'd0, word_count}, 32'd3);
    check("s1_fifo_level", {24'd0, wr_ptr - rd_ptr}, 32'd2);
    check("s1_fifo_head", {24'd0, fifo_data}, 32'h14);

    // 2: unbounded drain of 4 words, restart during done is ignored
    push_word(8'h16);
    push_word(8'h17);
    pc0 = pop_cnt; rb = rx_q.size(); dc = done_cnt;
    start_drain(8'd0);
    wait_done("s2", 40);
    drain_start = 1'b1;
    drain_len   = 8'd2;
    tick();
    drain_start = 1'b0;
    tick(); tick();
    check("s2_restart_ignored", {31'd0, busy}, 32'd0);
    check("s2_pops", pop_cnt - pc0, 4);
    check("s2_rx_n", rx_q.size() - rb, 4);
    for (int i = 0; i < 4; i++) check_rx("s2_word", rb, i, 8'h14 + 8'(i), 1'b0);
    check("s2_done_n", done_cnt - dc, 1);
    check("s2_word_count", {24'd0, word_count}, 32'd4);
    check("s2_fifo_empty", {31'd0, fifo_empty}, 32'd1);

    // abort while idle does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 32'd0);

    // 3: backpressure
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h31 + 8'(i));
    pc0 = pop_cnt; rb = rx_q.size();
    start_drain(8'd5);
    repeat (10) tick();
    check("s3_pops_held", pop_cnt - pc0, 2);
    check("s3_pop_req_n", {31'd0, fifo_pop_req_n}, 32'd1);
    check("s3_m_valid", {31'd0, m_valid}, 32'd1);
    check("s3_m_data_hold", {24'd0, m_data}, 32'h31);
    m_ready = 1'b1;
    wait_done("s3", 40);
    tick(); tick();
    check("s3_pops", pop_cnt - pc0, 5);
    check("s3_rx_n", rx_q.size() - rb, 5);
    for (int i = 0; i < 5; i++) check_rx("s3_word", rb, i, 8'h31 + 8'(i), i == 4);

    // 4: bounded drain waiting on a slow FIFO
    pc0 = pop_cnt; rb = rx_q.size();
    start_drain(8'd2);
    busy_bad = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) push_word(8'hA0);
      if (c == 9) push_word(8'hA1);
      tick();
      if (!busy) busy_bad++;
      if (c == 7) check("s4_first_pop", pop_cnt - pc0, 1);
    end
    check("s4_busy_throughout", busy_bad, 0);
    wait_done("s4", 20);
    tick(); tick();
    check("s4_pops", pop_cnt - pc0, 2);
    check_rx("s4_w0", rb, 0, 8'hA0, 1'b0);
    check_rx("s4_w1", rb, 1, 8'hA1, 1'b1);

    // 5: abort after two pops under backpressure
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'h51 + 8'(i));
    pc0 = pop_cnt; rb = rx_q.size(); dc = done_cnt;
    start_drain(8'd6);
    repeat (4) tick();
    check("s5_pops_before_abort", pop_cnt - pc0, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    check("s5_flush_busy", {31'd0, busy}, 32'd1);
    m_ready = 1'b1;
    wait_done("s5", 20);
    tick(); tick();
    check("s5_pops", pop_cnt - pc0, 2);
    check("s5_rx_n", rx_q.size() - rb, 2);
    check_rx("s5_w0", rb, 0, 8'h51, 1'b0);
    check_rx("s5_w1", rb, 1, 8'h52, 1'b0);
    check("s5_done_n", done_cnt - dc, 1);
    check("s5_word_count", {24'd0, word_count}, 32'd2);

    // 6: asynchronous reset mid-burst, then a single-word burst
    m_ready = 1'b0;
    pc0 = pop_cnt;
    start_drain(8'd4);
    repeat (4) tick();
    check("s6_buffered", pop_cnt - pc0, 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("s6_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("s6_rst_m_data", {24'd0, m_data}, 32'd0);
    check("s6_rst_m_last", {31'd0, m_last}, 32'd0);
    check("s6_rst_pop_req_n", {31'd0, fifo_pop_req_n}, 32'd1);
    check("s6_rst_busy", {31'd0, busy}, 32'd0);
    check("s6_rst_word_count", {24'd0, word_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push_word(8'h61);
    m_ready = 1'b1;
    pc0 = pop_cnt; rb = rx_q.size(); dc = done_cnt;
    start_drain(8'd1);
    wait_done("s6", 20);
    tick(); tick();
    check("s6_pops", pop_cnt - pc0, 1);
    check("s6_rx_n", rx_q.size() - rb, 1);
    check_rx("s6_w0", rb, 0, 8'h61, 1'b1);
    check("s6_done_n", done_cnt - dc, 1);
    check("s6_word_count", {24'd0, word_count}, 32'd1);

    check("pop_when_empty", pop_err, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
Pop-side controller for the team's show-ahead `fifo` (active-low `pop_req_n`, `data_out` valid whenever `!empty`). On a drain command it pops a bounded or unbounded burst of words and presents them on a valid/ready stream with a last-word marker. It sits between spike/event FIFOs and downstream neuron-update consumers. A 2-entry output buffer keeps `fifo_pop_req_n` free of any combinational path from `m_ready`.

Parameters:
- `width`, 8, data word width; must match the FIFO.
- `len_w`, 8, width of the burst-length request and the word counter.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `fifo_empty` in 1 — FIFO empty flag.
- `fifo_data` in width — FIFO head word; valid when `!fifo_empty`.
- `fifo_pop_req_n` out 1 — active-low pop request to the FIFO.
- `drain_start` in 1 — one-cycle command; honoured only in IDLE.
- `drain_len` in len_w — number of words to drain; 0 means drain until the FIFO is empty.
- `abort` in 1 — stop popping; already-buffered words are still delivered.
- `m_valid` out 1 — output word valid.
- `m_data` out width — output word.
- `m_last` out 1 — qualifies `m_data` as the final word of a counted burst.
- `m_ready` in 1 — downstream accept.
- `busy` out 1 — high when state != IDLE.
- `done` out 1 — one-cycle pulse when a burst completes.
- `word_count` out len_w — words popped in the current or last burst.

Behaviour:
- Reset (async, `rst_n` low): state = IDLE, buffer count = 0, `fifo_pop_req_n` = 1, `m_valid` = 0, `m_last` = 0, `m_data` = 0, `busy` = 0, `done` = 0, `word_count` = 0, remaining = 0.
- Reset mid-burst: all buffered words are discarded and the FIFO is left untouched. The FIFO is on the same reset.

States:
- IDLE --`drain_start`--> DRAIN.
  - Latches remaining = `drain_len` and sets mode = unbounded if `drain_len` == 0.
  - Clears `word_count`.
  - `drain_start` outside IDLE is ignored.
- DRAIN --(bounded and remaining == 0) or abort or (unbounded and `fifo_empty`)--> FLUSH.
- FLUSH --buffer count == 0--> IDLE, with `done` = 1 in that transition cycle.

Pop rule (combinational):
- `fifo_pop_req_n` = !(state == DRAIN && !`fifo_empty` && buffer count < 2 && !`abort` && (unbounded || remaining != 0)).
- Buffer count is the registered occupancy, so no `m_ready` to `fifo_pop_req_n` path exists.
- On a pop cycle:
  - `fifo_data` is written into the buffer at the same edge.
  - `word_count` += 1; saturates at 2^len_w - 1 in unbounded mode.
  - remaining -= 1 in bounded mode.
- Latency: FIFO head to `m_valid` is 1 cycle.

Output buffer:
- 2-entry in-order queue; head drives `m_data`.
- `m_valid` = count != 0.
- Transfer occurs when `m_valid` && `m_ready`.
- Simultaneous push and transfer leaves the count unchanged.
- Each entry stores a last bit, set when the pop decrements remaining from 1 to 0 in bounded mode.
- `m_last` = head entry's last bit.
- Unbounded mode and aborted bursts never assert `m_last`.
- `m_data` holds its value while `m_valid` && !`m_ready`.

Boundary conditions:
- FIFO empty during a bounded DRAIN: wait in DRAIN; no timeout.
- Abort while in IDLE or FLUSH: no effect.
- `drain_start` in the same cycle that `done` pulses: ignored; the command must be reissued in IDLE.
- `drain_len` = 1: exactly one pop, `m_last` asserted on that word.

Decomposition:
- Package `fifo_drain_pkg`:
  - state enum `drain_state_t` {IDLE, DRAIN, FLUSH};
  - buffer entry struct {data, last}.
- Sub-module `out_buf2`: 2-entry valid/ready queue carrying the last bit. Top level holds the FSM, counters and pop logic.

Test Plan:
1. FIFO preloaded with 0x11..0x15, `drain_len` = 3, `m_ready` = 1 → exactly 3 pops; `m_data` 0x11, 0x12, 0x13 with `m_last` only on 0x13; `done` pulses once; `word_count` = 3; FIFO retains 0x14, 0x15.
2. FIFO holds 4 words, `drain_len` = 0 → 4 pops; `m_last` never high; `done` after the 4th transfer; `word_count` = 4; FIFO empty.
3. Backpressure: `drain_len` = 5, `m_ready` = 0 for 10 cycles → exactly 2 pops then `fifo_pop_req_n` stays 1; `m_data` stable at the first word; on release all 5 words arrive in order.
4. FIFO empty, `drain_len` = 2, push 0xA0 at cycle 5 and 0xA1 at cycle 9 → pops track each arrival; `m_last` on 0xA1; `busy` high throughout.
5. `drain_len` = 6 with `abort` after the 2nd pop and `m_ready` = 0 → no further pops; 2 buffered words delivered without `m_last`; `done` pulses; `word_count` = 2.
6. Assert `rst_n` low during DRAIN with 2 words buffered → all outputs at reset values immediately (asynchronously); a subsequent `drain_len` = 1 command behaves as in scenario 1.
